// File: rtl/imem_fetch_buffer_if.sv
// Bus bundle between the instruction fetch buffer and its consumer/loader.
// Carries the program-load port, the branch redirect and the valid/ready
// instruction stream toward the Fetch stage.
interface imem_fetch_buffer_if #(
  parameter int N  = 32,
  parameter int AW = 6,
  parameter int CW = 3
);
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [N-1:0]  load_data;
  logic          redirect;
  logic [63:0]   redirect_pc;
  logic          instr_ready;
  logic          instr_valid;
  logic [N-1:0]  instr;
  logic [63:0]   instr_pc;
  logic [CW-1:0] fifo_count;

  // Pipeline side: loads programs, steers fetch and consumes instructions.
  modport master (
    output load_en, load_addr, load_data, redirect, redirect_pc, instr_ready,
    input  instr_valid, instr, instr_pc, fifo_count
  );

  // Fetch buffer side.
  modport slave (
    input  load_en, load_addr, load_data, redirect, redirect_pc, instr_ready,
    output instr_valid, instr, instr_pc, fifo_count
  );
endinterface

// File: rtl/imem_fetch_buffer.sv
// Writable instruction memory with a prefetch engine feeding a small FIFO.
// The memory is single-ported: a program load steals the port for that cycle.
// A read issued at one edge lands in the FIFO at the next edge; issue is
// throttled by counting FIFO occupancy plus the read in flight, so the FIFO
// can never overflow. Redirect discards everything prefetched.
module imem_fetch_buffer #(
  parameter int          N          = 32,
  parameter int          DEPTH      = 64,
  parameter int          AW         = $clog2(DEPTH),
  parameter int          FIFO_DEPTH = 4,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input logic                clk,
  input logic                reset,
  imem_fetch_buffer_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [N-1:0] mem [DEPTH];

  logic [63:0]   fetch_pc_reg;
  logic          rd_valid_reg;
  logic [N-1:0]  rd_data_reg;
  logic [63:0]   rd_pc_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  logic [FIFO_DEPTH-1:0][N-1:0] fifo_data;
  logic [FIFO_DEPTH-1:0][63:0]  fifo_pc;

  logic [61:0]   word_idx;
  logic          in_range;
  logic [AW-1:0] rd_addr;
  logic [CW:0]   credits_used;
  logic          issue;
  logic          push;
  logic          pop;

  // Addresses past the end of memory read as zero, like the old ROM.
  assign word_idx     = fetch_pc_reg[63:2];
  assign in_range     = word_idx < 62'(DEPTH);
  assign rd_addr      = fetch_pc_reg[AW+1:2];
  // A read in flight already owns a FIFO slot.
  assign credits_used = {1'b0, count_reg} + (CW+1)'(rd_valid_reg);
  assign issue = !reset && !bus.redirect && !bus.load_en &&
                 (credits_used < (CW+1)'(FIFO_DEPTH));
  assign push  = rd_valid_reg && !bus.redirect;
  assign pop   = (count_reg != '0) && bus.instr_ready && !bus.redirect;

  // Memory array: loads win the port; prefetch reads are registered.
  always_ff @(posedge clk) begin
    if (bus.load_en && !reset) begin
      mem[bus.load_addr] <= bus.load_data;
    end
    if (issue) begin
      rd_data_reg <= in_range ? mem[rd_addr] : '0;
    end
  end

  // Prefetch PC and the in-flight read tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg <= RESET_PC;
      rd_valid_reg <= 1'b0;
      rd_pc_reg    <= '0;
    end else if (bus.redirect) begin
      fetch_pc_reg <= bus.redirect_pc & ~64'h3;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= issue;
      if (issue) begin
        rd_pc_reg    <= fetch_pc_reg;
        fetch_pc_reg <= fetch_pc_reg + 64'd4;
      end
    end
  end

  // FIFO pointers and occupancy; redirect empties the queue in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (bus.redirect) begin
      rd_ptr_reg <= wr_ptr_reg;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // One storage slot per FIFO entry, written when the tail points at it.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    logic [N-1:0] data_reg;
    logic [63:0]  pc_reg;

    // Entry capture; cleared at reset so the head reads zero afterwards.
    always_ff @(posedge clk) begin
      if (reset) begin
        data_reg <= '0;
        pc_reg   <= '0;
      end else if (push && (wr_ptr_reg == PW'(gi))) begin
        data_reg <= rd_data_reg;
        pc_reg   <= rd_pc_reg;
      end
    end

    assign fifo_data[gi] = data_reg;
    assign fifo_pc[gi]   = pc_reg;
  end

  assign bus.instr_valid = (count_reg != '0);
  assign bus.instr       = fifo_data[rd_ptr_reg];
  assign bus.instr_pc    = fifo_pc[rd_ptr_reg];
  assign bus.fifo_count  = count_reg;
endmodule

// File: tb/tb_imem_fetch_buffer.sv
// Self-checking bench for imem_fetch_buffer: a reset/stall vector table,
// directed multi-cycle sequences, then random traffic against a queue model.
module tb_imem_fetch_buffer;
  localparam int N     = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int FD    = 4;
  localparam int CW    = 3;
  localparam logic [63:0] RPC0 = 64'h0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_fetch_buffer_if #(.N(N), .AW(AW), .CW(CW)) bus ();

  imem_fetch_buffer #(
    .N(N), .DEPTH(DEPTH), .FIFO_DEPTH(FD), .RESET_PC(RPC0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: queue of delivered beats, an optional in-flight beat,
  // the next fetch PC and a copy of memory.
  typedef struct { logic [63:0] pc; logic [N-1:0] data; } beat_t;
  beat_t        mq[$];
  beat_t        infl[$];
  logic [63:0]  m_pc;
  logic [N-1:0] mmem [DEPTH];

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          ev;
    int          ec;
    logic [63:0] epc;
  } vec_t;
  vec_t vecs [17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] ref_word(input logic [63:0] pc);
    if ((pc >> 2) < 64'(DEPTH)) return mmem[pc[AW+1:2]];
    return '0;
  endfunction

  function automatic logic [N-1:0] loaded_word(input int i);
    return 32'hf8000000 + 32'(i) * 32'h8000 + 32'(i + 1);
  endfunction

  task automatic model_edge(input bit rst, input bit ld, input logic [AW-1:0] la,
                            input logic [N-1:0] ldd, input bit rd,
                            input logic [63:0] rpc, input bit rdy);
    bit    do_pop, do_push, do_issue;
    beat_t nb;
    if (rst) begin
      mq.delete();
      infl.delete();
      m_pc = RPC0;
      return;
    end
    do_pop   = (mq.size() != 0) && rdy && !rd;
    do_push  = (infl.size() != 0) && !rd;
    do_issue = !rd && !ld && ((mq.size() + infl.size()) < FD);
    nb.pc    = m_pc;
    nb.data  = ref_word(m_pc);
    if (ld) mmem[la] = ldd;
    if (rd) begin
      mq.delete();
      infl.delete();
      m_pc = {rpc[63:2], 2'b00};
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(infl[0]);
      infl.delete();
      if (do_issue) begin
        infl.push_back(nb);
        m_pc = m_pc + 64'd4;
      end
    end
  endtask

  task automatic compare_model();
    check("valid", 64'(bus.instr_valid), 64'(mq.size() != 0));
    check("count", 64'(bus.fifo_count), 64'(mq.size()));
    check("count_bound", 64'(bus.fifo_count <= 3'(FD)), 64'd1);
    if (mq.size() != 0) begin
      check("instr", 64'(bus.instr), 64'(mq[0].data));
      check("pc", bus.instr_pc, mq[0].pc);
    end
  endtask

  task automatic step(input bit rst, input bit ld, input logic [AW-1:0] la,
                      input logic [N-1:0] ldd, input bit rd,
                      input logic [63:0] rpc, input bit rdy);
    reset           = rst;
    bus.load_en     = ld;
    bus.load_addr   = la;
    bus.load_data   = ldd;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.instr_ready = rdy;
    if (!rst && !rd && rdy && bus.instr_valid === 1'b1)
      $display("[TB] beat pc=%h instr=%h", bus.instr_pc, bus.instr);
    @(posedge clk);
    model_edge(rst, ld, la, ldd, rd, rpc, rdy);
    #1;
    compare_model();
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, '0, '0, 1'b0, 64'h0, rdy);
  endtask

  task automatic redir(input logic [63:0] pc);
    step(1'b0, 1'b0, '0, '0, 1'b1, pc, 1'b1);
  endtask

  task automatic expect_beat(input string name, input logic [63:0] pc, input logic [N-1:0] d);
    check({name, "_valid"}, 64'(bus.instr_valid), 64'd1);
    check({name, "_pc"}, bus.instr_pc, pc);
    check({name, "_instr"}, 64'(bus.instr), 64'(d));
  endtask

  task automatic expect_empty(input string name);
    check({name, "_valid"}, 64'(bus.instr_valid), 64'd0);
    check({name, "_count"}, 64'(bus.fifo_count), 64'd0);
  endtask

  initial begin : main
    bit          r_rst, r_ld, r_rd, r_rdy;
    logic [63:0] r_pc;
    logic [AW-1:0] r_addr;
    logic [N-1:0]  r_data;

    foreach (mmem[i]) mmem[i] = '0;
    m_pc = RPC0;

    // Reset, ten stalled cycles, then release: pc 0..16 drain in order.
    vecs[0]  = '{1, 0, 0, 0, 64'h0};
    vecs[1]  = '{1, 0, 0, 0, 64'h0};
    vecs[2]  = '{0, 0, 0, 0, 64'h0};
    vecs[3]  = '{0, 0, 1, 1, 64'h0};
    vecs[4]  = '{0, 0, 1, 2, 64'h0};
    vecs[5]  = '{0, 0, 1, 3, 64'h0};
    vecs[6]  = '{0, 0, 1, 4, 64'h0};
    vecs[7]  = '{0, 0, 1, 4, 64'h0};
    vecs[8]  = '{0, 0, 1, 4, 64'h0};
    vecs[9]  = '{0, 0, 1, 4, 64'h0};
    vecs[10] = '{0, 0, 1, 4, 64'h0};
    vecs[11] = '{0, 0, 1, 4, 64'h0};
    vecs[12] = '{0, 1, 1, 3, 64'h4};
    vecs[13] = '{0, 1, 1, 2, 64'h8};
    vecs[14] = '{0, 1, 1, 2, 64'hc};
    vecs[15] = '{0, 1, 1, 2, 64'h10};
    vecs[16] = '{0, 1, 1, 2, 64'h14};

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].rst, 1'b0, '0, '0, 1'b0, 64'h0, vecs[i].rdy);
      check($sformatf("vec%0d_valid", i), 64'(bus.instr_valid), 64'(vecs[i].ev));
      check($sformatf("vec%0d_count", i), 64'(bus.fifo_count), 64'(vecs[i].ec));
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_pc", i), bus.instr_pc, vecs[i].epc);
        check($sformatf("vec%0d_instr", i), 64'(bus.instr), 64'h0);
      end
    end

    // Program load, redirect to 0, then a full-rate stream past the end.
    for (int i = 0; i < 50; i++)
      step(1'b0, 1'b1, AW'(i), loaded_word(i), 1'b0, 64'h0, 1'b1);
    redir(64'h0);
    expect_empty("stream_r1");
    idle(1'b1);
    expect_empty("stream_r2");
    for (int k = 0; k < 66; k++) begin
      idle(1'b1);
      expect_beat($sformatf("stream%0d", k), 64'(4 * k),
                  (k < 50) ? loaded_word(k) : 32'h0);
    end

    // Mid-stream redirect to an unaligned target.
    redir(64'h82);
    expect_empty("redir_r1");
    idle(1'b1);
    expect_empty("redir_r2");
    idle(1'b1);
    expect_beat("redir_first", 64'h80, loaded_word(32));
    idle(1'b1);
    expect_beat("redir_second", 64'h84, loaded_word(33));

    // Loads on alternate cycles halve the issue rate without reordering.
    redir(64'h0);
    idle(1'b1);
    idle(1'b1);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, (k % 2) == 0, AW'(56 + (k / 2) % 8), $urandom, 1'b0, 64'h0, 1'b1);
      check($sformatf("alt%0d_valid", k), 64'(bus.instr_valid), 64'((k % 2) == 0));
      if ((k % 2) == 0)
        check($sformatf("alt%0d_pc", k), bus.instr_pc, 64'(4 + 2 * k));
    end

    // Reset overriding a load and a redirect; memory must be untouched.
    step(1'b1, 1'b1, AW'(5), 32'hdeadbeef, 1'b1, 64'h40, 1'b1);
    expect_empty("rst_mid");
    redir(64'h14);
    idle(1'b1);
    idle(1'b1);
    expect_beat("rst_mem", 64'h14, loaded_word(5));

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      r_rst  = ($urandom_range(0, 63) == 0);
      r_ld   = ($urandom_range(0, 5) == 0);
      r_rd   = ($urandom_range(0, 15) == 0);
      r_rdy  = ($urandom_range(0, 3) != 0);
      r_addr = AW'($urandom);
      r_data = $urandom;
      if ($urandom_range(0, 7) == 0) r_pc = {$urandom, $urandom};
      else r_pc = 64'($urandom_range(0, 'h120));
      step(r_rst, r_ld, r_addr, r_data, r_rd, r_pc, r_rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
